bsort_window_ctrl: RTL and testbench

//  Sliding-window sequencer for the 16-input bsort sorting network in the median filter.

---
 rtl/bsort_window_ctrl.sv | 124 ++++++++++++
 tb/tb_bsort_window_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bsort_window_ctrl.sv
// Sliding 16-sample window feeding a combinational bsort network, with a registered ranked output.
// Optional BSORT_RANK_SEL_EN adds a rank_sel port; otherwise the rank is the constant MED_IDX.
module bsort_window_ctrl #(
  parameter int DW      = 13,
  parameter int N       = 16,
  parameter int MED_IDX = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            flush,
  output logic [N*DW-1:0] sort_in,
  input  logic [N*DW-1:0] sort_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
`ifdef BSORT_RANK_SEL_EN
  input  logic [3:0]      rank_sel,
`endif
  output logic [4:0]      fill_cnt
);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_STALL
  } state_t;

  localparam logic [4:0] FILL_FULL = 5'(N);

  logic [4:0]    r_fill;
  logic          r_pend;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  state_t        w_state;
  logic          w_accept;
  logic          w_load;
  logic          w_sets_pend;
  logic [4:0]    w_fill_inc;
  logic [3:0]    w_rank;
  logic [DW-1:0] w_lane [N];

  // Status decode; pend only exists while the window is full, so STALL implies full.
  always_comb begin
    w_state = ST_FILL;
    if (r_fill == FILL_FULL) begin
      if (r_pend && r_out_valid && !out_ready) w_state = ST_STALL;
      else                                     w_state = ST_RUN;
    end
  end

  assign in_ready    = !flush && (w_state != ST_STALL);
  assign w_accept    = in_valid && in_ready;
  assign w_load      = r_pend && (!r_out_valid || out_ready);
  assign w_fill_inc  = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 5'd1;
  assign w_sets_pend = w_accept && (w_fill_inc == FILL_FULL);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_win
      logic [DW-1:0] r_word;
      logic [DW-1:0] w_shift_in;
      if (gi == 0) begin : g_head
        assign w_shift_in = in_data;
      end else begin : g_tail
        assign w_shift_in = g_win[gi-1].r_word;
      end

      always_ff @(posedge clk) begin
        if (reset || flush)  r_word <= '0;
        else if (w_accept)   r_word <= w_shift_in;
      end

      assign sort_in[DW*gi +: DW] = r_word;
      assign w_lane[gi]           = sort_out[DW*gi +: DW];
    end
  endgenerate

`ifdef BSORT_RANK_SEL_EN
  logic [3:0] r_rank;

  // Rank travels with the pending result so later rank_sel changes cannot alter it.
  always_ff @(posedge clk) begin
    if (reset)                       r_rank <= '0;
    else if (!flush && w_sets_pend)  r_rank <= rank_sel;
  end

  assign w_rank = r_rank;
`else
  assign w_rank = 4'(MED_IDX);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill      <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (flush)         r_fill <= '0;
      else if (w_accept) r_fill <= w_fill_inc;

      // An accept on the load edge re-arms pend for the freshly shifted window.
      if (flush)            r_pend <= 1'b0;
      else if (w_sets_pend) r_pend <= 1'b1;
      else if (w_load)      r_pend <= 1'b0;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_lane[w_rank];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign fill_cnt  = r_fill;

endmodule

// File: tb/tb_bsort_window_ctrl.sv
// Directed bench for bsort_window_ctrl with a behavioural 16-lane ascending sorter attached.
// Rank-select steps are compiled only when BSORT_RANK_SEL_EN is defined.
module tb_bsort_window_ctrl;
  localparam int DW = 13;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            flush;
  logic [N*DW-1:0] sort_in;
  logic [N*DW-1:0] sort_out;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [4:0]      fill_cnt;
`ifdef BSORT_RANK_SEL_EN
  logic [3:0]      rank_sel;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bsort_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .sort_in   (sort_in),
    .sort_out  (sort_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BSORT_RANK_SEL_EN
    .rank_sel  (rank_sel),
`endif
    .fill_cnt  (fill_cnt)
  );

  function automatic logic [N*DW-1:0] sort16(input logic [N*DW-1:0] x);
    logic [DW-1:0] a [N];
    logic [DW-1:0] t;
    logic [N*DW-1:0] y;
    for (int i = 0; i < N; i++) a[i] = x[DW*i +: DW];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    y = '0;
    for (int i = 0; i < N; i++) y[DW*i +: DW] = a[i];
    return y;
  endfunction

  assign sort_out = sort16(sort_in);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
`ifdef BSORT_RANK_SEL_EN
    rank_sel = 4'd7;
`endif
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_fill",      32'(fill_cnt), 0);
    check("rst_in_ready",  32'(in_ready), 1);

    // Steps 1/2: 1..18 back to back, consumer always ready
    for (int v = 1; v <= 16; v++) begin
      push(13'(v));
      check($sformatf("t1_nvalid_%0d", v), 32'(out_valid), 0);
    end
    check("t1_fill16", 32'(fill_cnt), 16);
    in_valid = 1'b1; in_data = 13'd17; #1;
    check("t2_ready17", 32'(in_ready), 1);
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data8", 32'(out_data), 8);
    in_data = 13'd18; #1;
    check("t2_ready18", 32'(in_ready), 1);
    tick();
    check("t2_data9", 32'(out_data), 9);
    in_valid = 1'b0;
    tick();
    check("t2_data10", 32'(out_data), 10);
    check("t2_valid10", 32'(out_valid), 1);
    tick();
    check("t2_drain", 32'(out_valid), 0);

    // Step 3: backpressure with a full window
    do_reset();
    for (int v = 1; v <= 16; v++) push(13'(v));
    tick(); tick();
    check("t3_idle", 32'(out_valid), 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 13'd17; #1;
    check("t3_ready17", 32'(in_ready), 1);
    tick();
    in_data = 13'd18; #1;
    check("t3_ready18", 32'(in_ready), 1);
    tick();
    check("t3_data9", 32'(out_data), 9);
    in_data = 13'd19; #1;
    check("t3_stall_ready", 32'(in_ready), 0);
    tick();
    check("t3_hold_a", 32'(out_data), 9);
    check("t3_hold_rdy", 32'(in_ready), 0);
    tick();
    check("t3_hold_b", 32'(out_data), 9);
    check("t3_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1; #1;
    check("t3_release_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t3_data10", 32'(out_data), 10);
    tick();
    check("t3_data11", 32'(out_data), 11);
    tick();
    check("t3_drain", 32'(out_valid), 0);

    // Step 4: flush drops the concurrent sample and empties the window
    do_reset();
    for (int v = 1; v <= 10; v++) push(13'(v));
    check("t4_fill10", 32'(fill_cnt), 10);
    in_valid = 1'b1; in_data = 13'd99; flush = 1'b1; #1;
    check("t4_flush_rdy", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_fill0", 32'(fill_cnt), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) push(13'd4095);
    check("t4_fill15", 32'(fill_cnt), 15);
    tick();
    check("t4_nvalid15", 32'(out_valid), 0);
    push(13'd4095);
    check("t4_fill16", 32'(fill_cnt), 16);
    tick();
    check("t4_valid", 32'(out_valid), 1);
    check("t4_data", 32'(out_data), 4095);

    // Step 5: reset while a result is held
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("t5_valid", 32'(out_valid), 0);
    check("t5_data", 32'(out_data), 0);
    check("t5_fill", 32'(fill_cnt), 0);
    check("t5_ready", 32'(in_ready), 1);
    out_ready = 1'b1;

`ifdef BSORT_RANK_SEL_EN
    // Step 6: rank selection, captured with the pending result
    do_reset();
    rank_sel = 4'd15;
    for (int i = 0; i < 16; i++) push(13'(16 - i));
    tick();
    check("t6_rank15", 32'(out_data), 16);
    do_reset();
    out_ready = 1'b0;
    rank_sel = 4'd0;
    for (int i = 0; i < 16; i++) push(13'(16 - i));
    rank_sel = 4'd15;
    push(13'd17);
    check("t6_rank0", 32'(out_data), 1);
    rank_sel = 4'd0; #1;
    check("t6_stall_rdy", 32'(in_ready), 0);
    tick();
    check("t6_hold", 32'(out_data), 1);
    out_ready = 1'b1;
    tick();
    check("t6_pending_rank", 32'(out_data), 17);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
